// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module   : divider
// Purpose  : Iterative 32-bit restoring divider, signed (DIV) or unsigned
//            (DIVU). One quotient bit per clock, MSB first, 32 steps. The
//            result is packed for direct loading into HiLo.
// Ports    : clk      - rising-edge clock
//            reset    - asynchronous active-low reset
//            dataA    - dividend, sampled on the accept edge only
//            dataB    - divisor, sampled on the accept edge only
//            Signal   - op code; DIVU / DIV start a divide, others are no-ops
//            dataOut  - {remainder[63:32], quotient[31:0]}
//            busy     - high while the 32 iteration steps are running
//            done     - one-cycle pulse when dataOut holds a new result
//            divzero  - accepted divisor was zero; held until next accept
// Revision : 1.0  initial release
// ============================================================================
module divider #(
  parameter logic [5:0] DIVU = 6'b011011,
  parameter logic [5:0] DIV  = 6'b011010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [63:0] dataOut,
  output logic        busy,
  output logic        done,
  output logic        divzero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Counter value during the 32nd (final) iteration step.
  localparam logic [5:0] c_last_step = 6'd31;

  state_t      r_state;
  state_t      w_next;

  logic [5:0]  r_count;
  logic [31:0] r_dvd;      // dividend magnitude; quotient bits shift in at LSB
  logic [31:0] r_dsr;      // divisor magnitude
  logic [31:0] r_rem;      // partial remainder
  logic        r_neg_q;    // negate quotient at the end
  logic        r_neg_r;    // negate remainder at the end
  logic        r_dz_pend;  // divisor was zero, reported at completion
  logic        r_dz;
  logic [63:0] r_out;

  logic        w_start;
  logic        w_accept;
  logic        w_last;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_q_nxt;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  // --------------------------------------------------------------------------
  // Operand conditioning at accept time
  // --------------------------------------------------------------------------
  assign w_start  = (Signal == DIVU) || (Signal == DIV);
  assign w_accept = (r_state == IDLE) && w_start;
  assign w_signed = (Signal == DIV);
  assign w_a_neg  = w_signed & dataA[31];
  assign w_b_neg  = w_signed & dataB[31];
  // 0x80000000 negates to itself, which is its correct unsigned magnitude.
  assign w_a_mag  = w_a_neg ? (32'd0 - dataA) : dataA;
  assign w_b_mag  = w_b_neg ? (32'd0 - dataB) : dataB;

  // --------------------------------------------------------------------------
  // One restoring step. The remainder is always below the divisor (or, for a
  // zero divisor, a prefix of the dividend), so the shifted value fits in 33
  // bits and bit 32 of the difference is a reliable borrow flag.
  // --------------------------------------------------------------------------
  assign w_shift   = {r_rem, r_dvd[31]};
  assign w_diff    = w_shift - {1'b0, r_dsr};
  assign w_ge      = ~w_diff[32];
  assign w_rem_nxt = w_ge ? w_diff[31:0] : w_shift[31:0];
  assign w_q_nxt   = {r_dvd[30:0], w_ge};

  // Sign correction applied to the values produced by the final step.
  assign w_q_fix   = r_neg_q ? (32'd0 - w_q_nxt)   : w_q_nxt;
  assign w_r_fix   = r_neg_r ? (32'd0 - w_rem_nxt) : w_rem_nxt;

  assign w_last    = (r_state == RUN) && (r_count == c_last_step);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. FINISH always falls back to IDLE, so with Signal held
  // a new divide is taken on the following edge, giving a 34-cycle cadence.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = RUN;
      RUN:     if (r_count == c_last_step) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= 6'd0;
      r_dvd     <= 32'd0;
      r_dsr     <= 32'd0;
      r_rem     <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz_pend <= 1'b0;
      r_dz      <= 1'b0;
      r_out     <= 64'd0;
    end else if (w_accept) begin
      r_count   <= 6'd0;
      r_dvd     <= w_a_mag;
      r_dsr     <= w_b_mag;
      r_rem     <= 32'd0;
      // Quotient is negative when signs differ; remainder follows dividend.
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_dz_pend <= (dataB == 32'd0);
      r_dz      <= 1'b0;
    end else if (r_state == RUN) begin
      r_count <= r_count + 6'd1;
      r_rem   <= w_rem_nxt;
      r_dvd   <= w_q_nxt;
      if (w_last) begin
        r_out <= {w_r_fix, w_q_fix};
        r_dz  <= r_dz_pend;
      end
    end
  end

  assign dataOut = r_out;
  assign busy    = (r_state == RUN);
  assign done    = (r_state == FINISH);
  assign divzero = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider
// Purpose  : Directed scoreboard bench for divider. Stimulus pushes the
//            expected result and completion cycle; a monitor pops and checks
//            on every done pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_divider;

  localparam logic [5:0] OP_DIVU = 6'b011011;
  localparam logic [5:0] OP_DIV  = 6'b011010;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic [31:0] dataA  = 32'd0;
  logic [31:0] dataB  = 32'd0;
  logic [5:0]  Signal = 6'd0;
  logic [63:0] dataOut;
  logic        busy;
  logic        done;
  logic        divzero;

  divider dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done),
    .divzero (divzero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] dout;
    logic        dz;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no result", cyc);
      end else begin
        e = sb.pop_front();
        chk("dataOut", dataOut, e.dout);
        chk("divzero", 64'(divzero), 64'(e.dz));
        chk("done_cycle", 64'(cyc), 64'(e.at));
        chk("busy_with_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic start(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] ed, input logic edz, input bit push);
    exp_t e;
    @(negedge clk);
    Signal = op;
    dataA  = a;
    dataB  = b;
    @(posedge clk);
    #1;
    Signal = 6'd0;
    if (push) begin
      e.dout = ed;
      e.dz   = edz;
      e.at   = cyc + 32;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, input int exp_busy);
    int nb;
    bit seen;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) nb++;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
  endtask

  task automatic run(input string name, input logic [5:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] ed, input logic edz);
    start(op, a, b, ed, edz, 1'b1);
    wait_done(name, 32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int seen;
    exp_t e;

    // Reset state
    #12;
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_divzero", 64'(divzero), 64'd0);
    chk("rst_dataOut", dataOut,      64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Non-divide op codes are ignored
    @(negedge clk);
    Signal = 6'b000001;
    dataA  = 32'd50;
    dataB  = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("noop_busy", 64'(busy), 64'd0);
    end
    Signal = 6'b011000;
    @(negedge clk);
    chk("noop2_busy", 64'(busy), 64'd0);
    Signal = 6'd0;

    run("divu_100_7",   OP_DIVU, 32'd100,      32'd7,        {32'd2, 32'd14},               1'b0);
    run("div_m7_2",     OP_DIV,  32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  1'b0);
    run("divu_by_zero", OP_DIVU, 32'h12345678, 32'd0,        {32'h12345678, 32'hFFFFFFFF},  1'b1);
    // divzero holds until the next accept
    @(negedge clk);
    chk("divzero_held", 64'(divzero), 64'd1);
    run("div_7_m2",     OP_DIV,  32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},         1'b0);
    run("div_m7_m2",    OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3},         1'b0);
    run("div_wrap",     OP_DIV,  32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000},         1'b0);
    run("divu_big_16",  OP_DIVU, 32'hFFFFFFFF, 32'd16,       {32'd15, 32'h0FFFFFFF},        1'b0);
    run("div_m100_0",   OP_DIV,  32'hFFFFFF9C, 32'd0,        {32'hFFFFFF9C, 32'd1},         1'b1);
    run("divu_5_9",     OP_DIVU, 32'd5,        32'd9,        {32'd5, 32'd0},                1'b0);

    // Inputs disturbed mid-operation must not affect the running divide
    start(OP_DIVU, 32'd1000, 32'd10, {32'd0, 32'd100}, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    Signal = OP_DIV;
    dataA  = 32'hFFFFFFCE;
    dataB  = 32'd3;
    wait_done("disturb", 22);
    Signal = 6'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_second_op", 64'(busy), 64'd0);
    end

    // Reset in the middle of a divide
    start(OP_DIVU, 32'd1000, 32'd7, 64'd0, 1'b0, 1'b0);
    repeat (16) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy",    64'(busy),    64'd0);
    chk("abort_done",    64'(done),    64'd0);
    chk("abort_dataOut", dataOut,      64'd0);
    chk("abort_divzero", 64'(divzero), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_still_idle", 64'(busy), 64'd0);
    reset = 1'b1;
    run("after_reset_9_3", OP_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

    // Back-to-back with Signal held
    @(negedge clk);
    Signal = OP_DIVU;
    dataA  = 32'hFFFFFFFF;
    dataB  = 32'd1;
    @(posedge clk);
    #1;
    acc = cyc;
    for (int k = 0; k < 3; k++) begin
      e.dout = {32'd0, 32'hFFFFFFFF};
      e.dz   = 1'b0;
      e.at   = acc + 32 + 34 * k;
      sb.push_back(e);
    end
    seen = 0;
    for (int i = 0; i < 120 && seen < 3; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    Signal = 6'd0;
    chk("b2b_results", 64'(seen), 64'd3);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
